// File: rtl/fetch_stage.sv
// Purpose: IF stage. Holds the PC, drives instruction memory and fills the IF/ID register.
//          A RUN/HALT FSM stops fetching at a zero word or at an out-of-range PC.
// Latency: imem_addr follows the PC combinationally. IF/ID is written one cycle after the fetch.
// Backpressure: stall holds the PC, the FSM and IF/ID. A redirect overrides stall.
//               A flush forces a bubble into IF/ID even while stalled.
// Ports:
//   clk, reset (sync, active-high)
//   stall, flush, redirect_valid/redirect_target      - control from later stages / hazard unit
//   imem_addr (out), imem_inst (in, combinational)     - instruction memory
//   if_id_pc, if_id_pc_plus4, if_id_inst, if_id_valid  - registered IF/ID payload
//   halted                                             - FSM in HALT
//   fetch_count                                        - valid instructions written to IF/ID
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 128,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pc_plus4;
    logic        end_fetch;
    logic        wr_ifid;    // IF/ID is written this cycle
    logic        wr_valid;   // the write carries a real instruction rather than a bubble

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign halted    = (state == HALT);
    assign end_fetch = (imem_inst == 32'h0) || (pc >= IMEM_LIMIT);

    always_comb begin
        pc_n     = pc;
        state_n  = state;
        wr_ifid  = 1'b0;
        wr_valid = 1'b0;
        if (redirect_valid) begin
            // A redirect wins over stall and restarts fetch even out of HALT.
            pc_n    = {redirect_target[31:2], 2'b00};
            state_n = RUN;
            wr_ifid = 1'b1;
        end else if (stall) begin
            // Everything holds. Only a flush may still clear IF/ID.
            wr_ifid = flush;
        end else begin
            wr_ifid = 1'b1;
            if (state == RUN) begin
                if (end_fetch) begin
                    state_n = HALT;
                end else begin
                    pc_n     = pc_plus4;
                    wr_valid = 1'b1;
                end
            end
        end
        // A flush discards the fetched word, but the PC still advances as computed above.
        if (flush) begin
            wr_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            state          <= RUN;
            if_id_pc       <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_inst     <= NOP_INST;
            if_id_valid    <= 1'b0;
            fetch_count    <= 32'h0;
        end else begin
            pc    <= pc_n;
            state <= state_n;
            if (wr_ifid) begin
                // Bubbles also record the current PC, which helps when tracing a dump.
                if_id_pc       <= pc;
                if_id_pc_plus4 <= pc_plus4;
                if_id_inst     <= wr_valid ? imem_inst : NOP_INST;
                if_id_valid    <= wr_valid;
            end
            if (wr_ifid && wr_valid) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: directed bench for fetch_stage. Two instances are used: one with the default
//          reset PC and one with reset PC 124, which exercises the out-of-range halt.
// Latency/backpressure: inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] IA  = 32'h0050_0093;
    localparam logic [31:0] IB  = 32'h00a0_0113;
    localparam logic [31:0] IC  = 32'h0020_81b3;
    localparam logic [31:0] ID  = 32'h0010_0213;
    localparam logic [31:0] IE  = 32'h0030_0293;
    localparam logic [31:0] IF  = 32'h0040_0313;

    logic        clk = 1'b0;
    logic [31:0] mem [0:31];

    // instance 0: default RESET_PC
    logic        reset0 = 1'b1, stall0 = 1'b0, flush0 = 1'b0, redir0 = 1'b0;
    logic [31:0] target0 = 32'h0;
    logic [31:0] addr0, inst0, pc0, pcp40, ifinst0, cnt0;
    logic        valid0, halted0;

    // instance 1: RESET_PC = 124
    logic        reset1 = 1'b1, stall1 = 1'b0, flush1 = 1'b0, redir1 = 1'b0;
    logic [31:0] target1 = 32'h0;
    logic [31:0] addr1, inst1, pc1, pcp41, ifinst1, cnt1;
    logic        valid1, halted1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Out-of-range reads return a nonzero word, so only the range check can cause a halt there.
    assign inst0 = (addr0 < 32'd128) ? mem[addr0[6:2]] : 32'hDEAD_BEEF;
    assign inst1 = (addr1 < 32'd128) ? mem[addr1[6:2]] : 32'hDEAD_BEEF;

    fetch_stage u0 (
        .clk(clk), .reset(reset0), .stall(stall0), .flush(flush0),
        .redirect_valid(redir0), .redirect_target(target0),
        .imem_addr(addr0), .imem_inst(inst0),
        .if_id_pc(pc0), .if_id_pc_plus4(pcp40), .if_id_inst(ifinst0),
        .if_id_valid(valid0), .halted(halted0), .fetch_count(cnt0)
    );

    fetch_stage #(.RESET_PC(32'd124)) u1 (
        .clk(clk), .reset(reset1), .stall(stall1), .flush(flush1),
        .redirect_valid(redir1), .redirect_target(target1),
        .imem_addr(addr1), .imem_inst(inst1),
        .if_id_pc(pc1), .if_id_pc_plus4(pcp41), .if_id_inst(ifinst1),
        .if_id_valid(valid1), .halted(halted1), .fetch_count(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0]  = IA;
        mem[1]  = IB;
        mem[2]  = IC;
        mem[8]  = IE;   // 0x20
        mem[9]  = IF;   // 0x24
        mem[31] = ID;   // 0x7c = 124

        // reset state
        step();
        step();
        check("rst_addr",  addr0,   32'h0);
        check("rst_inst",  ifinst0, NOP);
        check("rst_valid", {31'b0, valid0}, 32'h0);
        check("rst_pc",    pc0,     32'h0);
        check("rst_pcp4",  pcp40,   32'h0);
        check("rst_cnt",   cnt0,    32'h0);
        check("rst_halt",  {31'b0, halted0}, 32'h0);

        // straight-line fetch at 0
        reset0 = 1'b0;
        step();
        check("f0_pc",    pc0,     32'h0);
        check("f0_inst",  ifinst0, IA);
        check("f0_valid", {31'b0, valid0}, 32'h1);
        check("f0_addr",  addr0,   32'h4);

        // two-cycle stall while PC = 4
        stall0 = 1'b1;
        step();
        step();
        check("st_addr",  addr0,   32'h4);
        check("st_pc",    pc0,     32'h0);
        check("st_inst",  ifinst0, IA);
        check("st_valid", {31'b0, valid0}, 32'h1);
        check("st_cnt",   cnt0,    32'h1);
        stall0 = 1'b0;
        step();
        check("f4_pc",    pc0,     32'h4);
        check("f4_inst",  ifinst0, IB);
        check("f4_pcp4",  pcp40,   32'h8);
        check("f4_cnt",   cnt0,    32'h2);
        step();
        check("f8_pc",    pc0,     32'h8);
        check("f8_inst",  ifinst0, IC);
        check("f8_cnt",   cnt0,    32'h3);
        check("f8_addr",  addr0,   32'hc);

        // zero word at 12 -> HALT
        step();
        check("h_halt",   {31'b0, halted0}, 32'h1);
        check("h_addr",   addr0,   32'hc);
        check("h_cnt",    cnt0,    32'h3);
        check("h_valid",  {31'b0, valid0}, 32'h0);
        check("h_inst",   ifinst0, NOP);
        check("h_pc",     pc0,     32'hc);
        check("h_pcp4",   pcp40,   32'h10);
        step();
        check("h2_halt",  {31'b0, halted0}, 32'h1);
        check("h2_addr",  addr0,   32'hc);

        // redirect out of HALT to 0x4
        redir0 = 1'b1; target0 = 32'h4;
        step();
        check("rh_halt",  {31'b0, halted0}, 32'h0);
        check("rh_addr",  addr0,   32'h4);
        check("rh_valid", {31'b0, valid0}, 32'h0);
        redir0 = 1'b0;
        step();
        check("rh_f_valid", {31'b0, valid0}, 32'h1);
        check("rh_f_pc",  pc0,     32'h4);
        check("rh_f_inst", ifinst0, IB);
        check("rh_f_cnt", cnt0,    32'h4);

        // redirect to 0x22 together with stall: target aligned, bubble written
        redir0 = 1'b1; target0 = 32'h22; stall0 = 1'b1;
        step();
        check("rs_addr",  addr0,   32'h20);
        check("rs_valid", {31'b0, valid0}, 32'h0);
        check("rs_inst",  ifinst0, NOP);
        check("rs_cnt",   cnt0,    32'h4);
        redir0 = 1'b0; stall0 = 1'b0;
        step();
        check("rs_f_pc",  pc0,     32'h20);
        check("rs_f_inst", ifinst0, IE);
        check("rs_f_cnt", cnt0,    32'h5);
        check("rs_f_addr", addr0,  32'h24);

        // flush with stall: bubble, PC and count held
        flush0 = 1'b1; stall0 = 1'b1;
        step();
        check("fs_valid", {31'b0, valid0}, 32'h0);
        check("fs_inst",  ifinst0, NOP);
        check("fs_addr",  addr0,   32'h24);
        check("fs_cnt",   cnt0,    32'h5);

        // flush without stall: fetched word discarded, PC still advances
        stall0 = 1'b0;
        step();
        check("fl_valid", {31'b0, valid0}, 32'h0);
        check("fl_inst",  ifinst0, NOP);
        check("fl_addr",  addr0,   32'h28);
        check("fl_cnt",   cnt0,    32'h5);
        flush0 = 1'b0;

        // reset during stall
        stall0 = 1'b1; reset0 = 1'b1;
        step();
        check("rst2_addr", addr0,  32'h0);
        check("rst2_cnt",  cnt0,   32'h0);
        check("rst2_valid", {31'b0, valid0}, 32'h0);
        stall0 = 1'b0;

        // instance 1: one fetch at 124, then PC 128 is out of range
        reset1 = 1'b0;
        check("or_start", addr1, 32'd124);
        step();
        check("or_pc",    pc1,     32'd124);
        check("or_inst",  ifinst1, ID);
        check("or_valid", {31'b0, valid1}, 32'h1);
        check("or_addr",  addr1,   32'd128);
        check("or_cnt",   cnt1,    32'h1);
        step();
        check("or_halt",  {31'b0, halted1}, 32'h1);
        check("or_haddr", addr1,   32'd128);
        check("or_hcnt",  cnt1,    32'h1);
        check("or_hvalid", {31'b0, valid1}, 32'h0);
        // reset from HALT
        reset1 = 1'b1;
        step();
        check("or_rst_addr", addr1, 32'd124);
        check("or_rst_halt", {31'b0, halted1}, 32'h0);
        check("or_rst_cnt",  cnt1,  32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 The block SHALL have parameter IMEM_BYTES, default 128, the instruction-memory size in bytes; PCs at or above it are out of range.
REQ-003 The block SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), the bubble instruction.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous and active-high.
REQ-006 The block SHALL have port stall, input, 1 bit, the hazard-unit request to hold PC and IF/ID.
REQ-007 The block SHALL have port flush, input, 1 bit, the request to replace the IF/ID contents with a bubble.
REQ-008 The block SHALL have port redirect_valid, input, 1 bit, a taken branch or jump from a later stage.
REQ-009 The block SHALL have port redirect_target, input, 32 bits, the new fetch address.
REQ-010 The block SHALL have port imem_addr, output, 32 bits, the byte address driven to instruction memory.
REQ-011 The block SHALL have port imem_inst, input, 32 bits, the combinational instruction word returned for imem_addr.
REQ-012 The block SHALL have ports if_id_pc, if_id_pc_plus4 and if_id_inst, outputs, 32 bits each, the registered IF/ID payload.
REQ-013 The block SHALL have port if_id_valid, output, 1 bit, high when the IF/ID payload is a real fetched instruction.
REQ-014 The block SHALL have port halted, output, 1 bit, high while the FSM is in HALT.
REQ-015 The block SHALL have port fetch_count, output, 32 bits, the number of valid instructions written into IF/ID.

Function
REQ-016 The block SHALL drive imem_addr combinationally from the PC register with no added latency.
REQ-017 The block SHALL implement a two-state FSM: RUN and HALT.
REQ-018 The block SHALL classify a fetch as "end" when imem_inst == 32'h0 or PC >= IMEM_BYTES.
REQ-019 The PC update priority SHALL be: reset > redirect_valid > stall > FSM action.
REQ-020 On redirect_valid, the block SHALL load PC <= {redirect_target[31:2], 2'b00}, set the state to RUN (also from HALT), and write a bubble into IF/ID, regardless of stall.
REQ-021 In RUN with no redirect, no stall and a non-end fetch, the block SHALL set PC <= PC+4, modulo 2^32 with wrap-around, and write {PC, PC+4, imem_inst, valid=1} into IF/ID.
REQ-022 In RUN with no redirect, no stall and an end fetch, the block SHALL hold PC, enter HALT, and write a bubble into IF/ID.
REQ-023 In HALT without redirect, the block SHALL hold PC and write a bubble into IF/ID every non-stalled cycle.
REQ-024 When stall=1 and redirect_valid=0, the block SHALL hold PC, FSM state and IF/ID unchanged, except as REQ-025 specifies.
REQ-025 When flush=1, the block SHALL write a bubble into IF/ID that cycle, overriding stall and any fetch; the PC SHALL still follow REQ-019.
REQ-026 A bubble SHALL be if_id_inst=NOP_INST, if_id_valid=0, if_id_pc=PC, if_id_pc_plus4=PC+4.
REQ-027 The block SHALL increment fetch_count by 1, wrapping at 2^32, in exactly the cycles that write if_id_valid=1.

Reset
REQ-028 When reset=1 at a clock edge, the block SHALL set PC=RESET_PC and state=RUN, overriding all other inputs including redirect.
REQ-029 On reset, the block SHALL set if_id_inst=NOP_INST, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0, fetch_count=0 and halted=0.
REQ-030 A reset asserted mid-stall or in HALT SHALL behave identically to REQ-028 and REQ-029 on the next edge.

Verification
REQ-031 The bench SHALL cover straight-line fetch: memory holds 3 words at 0, 4 and 8, then zeros -> IF/ID shows pc 0, 4, 8 with valid=1 on 3 consecutive cycles; then halted=1, PC=12 and fetch_count=3.
REQ-032 The bench SHALL cover stall: assert stall for 2 cycles while PC=4 -> imem_addr stays 4 and IF/ID holds the pc=0 payload; after release, pc=4 enters IF/ID.
REQ-033 The bench SHALL cover redirect with stall: redirect_valid=1, target=32'h0000_0022, stall=1 -> PC=32'h20, bubble in IF/ID (valid=0, inst=32'h13); the next cycle fetches at 0x20.
REQ-034 The bench SHALL cover redirect out of HALT: while halted, redirect to 0x4 -> halted=0 and the following cycle has valid=1 with if_id_pc=4.
REQ-035 The bench SHALL cover flush with stall: flush=1 and stall=1 together -> IF/ID becomes a bubble, PC is unchanged and fetch_count is unchanged.
REQ-036 The bench SHALL cover out-of-range and reset: set RESET_PC=124 with memory nonzero at 124 -> one valid fetch, then PC=128 triggers HALT; asserting reset then returns PC to 124 with halted=0 and fetch_count=0.
